tile_bank_cfg_loader: RTL and testbench



---
 rtl/tile_bank_cfg_loader.sv | 134 +++++++++++++
 tb/tb_tile_bank_cfg_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_bank_cfg_loader.sv
// Memory-bank configuration loader: gathers stream words into a full bl row, then pulses that
// row's word-line, walking from a programmable start row up to the last row of the bank.
module tile_bank_cfg_loader #(
    parameter int unsigned NUM_BL   = 158,
    parameter int unsigned NUM_WL   = 158,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned WL_PULSE = 2,
    localparam int unsigned RW      = (NUM_WL > 1) ? $clog2(NUM_WL) : 1
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic [RW-1:0]     start_row,
    input  logic              cfg_valid,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic [0:NUM_BL-1] bl,
    output logic [0:NUM_WL-1] wl,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned BEATS = (NUM_BL + DATA_W - 1) / DATA_W;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PW    = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

    localparam logic [BW-1:0] LastBeat  = BW'(BEATS - 1);
    localparam logic [PW-1:0] LastPulse = PW'(WL_PULSE - 1);
    localparam logic [RW-1:0] LastRow   = RW'(NUM_WL - 1);
    localparam logic [RW:0]   NumWl     = (RW + 1)'(NUM_WL);

    typedef enum logic [2:0] {StIdle, StLoad, StPulse, StHold, StDone} state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [0:NUM_BL-1] bl_q, bl_d;
    logic [0:NUM_WL-1] wl_q, wl_d;
    logic              err_q, err_d;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        beat_d  = beat_q;
        pcnt_d  = pcnt_q;
        bl_d    = bl_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if ({1'b0, start_row} < NumWl) begin
                        row_d   = start_row;
                        beat_d  = '0;
                        err_d   = 1'b0;
                        state_d = StLoad;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (cfg_valid) begin
                    // Beat k lands on bl[k*DATA_W +: DATA_W]; overhang bits of the last beat drop.
                    for (int i = 0; i < NUM_BL; i++) begin
                        if (beat_q == BW'(i / DATA_W)) begin
                            bl_d[i] = cfg_data[i % DATA_W];
                        end
                    end
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        pcnt_d  = '0;
                        state_d = StPulse;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StPulse: begin
                if (pcnt_q == LastPulse) begin
                    state_d = StHold;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            StHold: begin
                if (row_q == LastRow) begin
                    state_d = StDone;
                end else begin
                    row_d   = row_q + 1'b1;
                    beat_d  = '0;
                    state_d = StLoad;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Word-line is registered off the next state so it aligns exactly with PULSE.
        for (int i = 0; i < NUM_WL; i++) begin
            wl_d[i] = (state_d == StPulse) && (row_q == RW'(i));
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q <= StIdle;
            row_q   <= '0;
            beat_q  <= '0;
            pcnt_q  <= '0;
            bl_q    <= '0;
            wl_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            beat_q  <= beat_d;
            pcnt_q  <= pcnt_d;
            bl_q    <= bl_d;
            wl_q    <= wl_d;
            err_q   <= err_d;
        end
    end

    assign cfg_ready = (state_q == StLoad);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign bl        = bl_q;
    assign wl        = wl_q;
    assign err       = err_q;

endmodule

// File: tb/tb_tile_bank_cfg_loader.sv
// Self-checking bench for tile_bank_cfg_loader at default parameters, using a row-level model
// built from the stream words to predict bl contents, wl pulse order/length and done timing.
module tb_tile_bank_cfg_loader;

    localparam int NBL    = 158;
    localparam int NWL    = 158;
    localparam int WP     = 2;
    localparam int BEATS  = 20;
    localparam int ROWCYC = BEATS + WP + 1;

    logic           prog_clk  = 1'b0;
    logic           pReset_n  = 1'b1;
    logic           start     = 1'b0;
    logic [7:0]     start_row = 8'd0;
    logic           cfg_valid = 1'b0;
    logic [7:0]     cfg_data  = 8'd0;
    logic           cfg_ready;
    logic [0:NBL-1] bl;
    logic [0:NWL-1] wl;
    logic           busy;
    logic           done;
    logic           err;

    int tests = 0;
    int fails = 0;
    logic [7:0] wq[$];

    always #5 prog_clk = ~prog_clk;

    tile_bank_cfg_loader dut (
        .prog_clk  (prog_clk),
        .pReset_n  (pReset_n),
        .start     (start),
        .start_row (start_row),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .bl        (bl),
        .wl        (wl),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Expected bl image for pass row i: beat k bit j -> bl[k*8+j], overhang dropped.
    function automatic logic [0:NBL-1] model_bl(input int i);
        logic [0:NBL-1] v;
        logic [7:0] w;
        v = '0;
        for (int k = 0; k < BEATS; k++) begin
            w = wq[i * BEATS + k];
            for (int j = 0; j < 8; j++) begin
                if (k * 8 + j < NBL) v[k * 8 + j] = w[j];
            end
        end
        return v;
    endfunction

    // dmode: 0 = byte (row+1), 1 = random, 2 = 0xFF. smode: 0 = no stall, 1 = toggle, 2 = random.
    task automatic run_pass(input int srow, input int dmode, input int smode, input bit poke,
                            input string tag);
        int nrows = NWL - srow;
        int idx = 0;
        int cyc = 0;
        bit tog = 1'b1;
        bit acc;
        int first_ready = -1;
        int done_cyc = -1;
        int done_cnt = 0;
        int multihot = 0;
        int ready_bad = 0;
        int unstable = 0;
        int acc_since = 0;
        bit in_pulse = 1'b0;
        int cur_row = -1;
        int n;
        int r;
        int after = 0;
        int busy_after = -1;
        int prow[$];
        int plen[$];
        int pstart[$];
        int pwords[$];
        logic [0:NBL-1] pbl[$];
        logic [0:NBL-1] snap;

        wq.delete();
        for (int i = 0; i < nrows; i++) begin
            for (int k = 0; k < BEATS; k++) begin
                if (dmode == 0) wq.push_back(8'(srow + i + 1));
                else if (dmode == 1) wq.push_back(8'($urandom));
                else wq.push_back(8'hFF);
            end
        end

        @(posedge prog_clk); #1;
        start = 1'b1;
        start_row = 8'(srow);
        @(posedge prog_clk); #1;
        start = 1'b0;
        cyc = 1;
        while (after < 4 && cyc < 12000) begin
            start = poke && (idx == 5);
            if (poke) start_row = 8'd0;
            if (idx < wq.size()) begin
                if (smode == 0) cfg_valid = 1'b1;
                else if (smode == 1) cfg_valid = tog;
                else cfg_valid = ($urandom_range(0, 3) != 0);
                cfg_data = wq[idx];
            end else begin
                cfg_valid = 1'b0;
                cfg_data = 8'($urandom);
            end
            tog = ~tog;

            @(negedge prog_clk);
            if (cyc == 1) begin
                tests++;
                if (busy !== 1'b1 || cfg_ready !== 1'b1 || err !== 1'b0) begin
                    fails++;
                    $display("FAIL %s cycle1: busy=%b ready=%b err=%b, want 1 1 0",
                             tag, busy, cfg_ready, err);
                end
            end
            if (cfg_ready && first_ready < 0) first_ready = cyc;
            acc = cfg_valid && cfg_ready;
            if (acc) acc_since++;
            n = $countones(wl);
            if (n > 1) multihot++;
            if (n == 1) begin
                r = -1;
                for (int k = 0; k < NWL; k++) if (wl[k]) r = k;
                if (cfg_ready) ready_bad++;
                if (in_pulse && r == cur_row) begin
                    plen[plen.size() - 1] = plen[plen.size() - 1] + 1;
                    if (bl !== snap) unstable++;
                end else begin
                    in_pulse = 1'b1;
                    cur_row = r;
                    snap = bl;
                    prow.push_back(r);
                    plen.push_back(1);
                    pstart.push_back(cyc);
                    pbl.push_back(bl);
                    pwords.push_back(acc_since);
                    acc_since = 0;
                end
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                if (cfg_ready) ready_bad++;
                if (bl !== snap) unstable++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    if (poke) begin
                        start = 1'b1;
                        start_row = 8'd0;
                    end
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
            if (done_cyc >= 0) after++;
            @(posedge prog_clk); #1;
            if (acc) idx++;
            cyc++;
        end
        start = 1'b0;
        cfg_valid = 1'b0;

        tests++;
        if (multihot !== 0) begin
            fails++;
            $display("FAIL %s multihot: got %0d cycles, want 0", tag, multihot);
        end
        tests++;
        if (ready_bad !== 0) begin
            fails++;
            $display("FAIL %s ready_in_pulse_hold: got %0d cycles, want 0", tag, ready_bad);
        end
        tests++;
        if (unstable !== 0) begin
            fails++;
            $display("FAIL %s bl_stable: got %0d changes, want 0", tag, unstable);
        end
        tests++;
        if (done_cnt !== 1) begin
            fails++;
            $display("FAIL %s done_count: got %0d, want 1", tag, done_cnt);
        end
        tests++;
        if (prow.size() !== nrows) begin
            fails++;
            $display("FAIL %s pulse_count: got %0d, want %0d", tag, prow.size(), nrows);
        end
        for (int i = 0; i < prow.size() && i < nrows; i++) begin
            tests++;
            if (prow[i] !== srow + i || plen[i] !== WP || pwords[i] !== BEATS) begin
                fails++;
                $display("FAIL %s pulse%0d: row=%0d len=%0d words=%0d, want %0d %0d %0d",
                         tag, i, prow[i], plen[i], pwords[i], srow + i, WP, BEATS);
            end
            tests++;
            if (pbl[i] !== model_bl(i)) begin
                fails++;
                $display("FAIL %s bl_row%0d: got %h, want %h", tag, srow + i, pbl[i],
                         model_bl(i));
            end
            if (smode == 0) begin
                tests++;
                if (i == 0 && pstart[0] - first_ready !== BEATS) begin
                    fails++;
                    $display("FAIL %s first_pulse_latency: got %0d, want %0d", tag,
                             pstart[0] - first_ready, BEATS);
                end else if (i > 0 && pstart[i] - pstart[i - 1] !== ROWCYC) begin
                    fails++;
                    $display("FAIL %s spacing%0d: got %0d, want %0d", tag, i,
                             pstart[i] - pstart[i - 1], ROWCYC);
                end
            end
        end
        if (smode == 0) begin
            tests++;
            if (done_cyc - first_ready !== nrows * ROWCYC) begin
                fails++;
                $display("FAIL %s done_latency: got %0d, want %0d", tag, done_cyc - first_ready,
                         nrows * ROWCYC);
            end
        end
        tests++;
        if (busy_after !== 0 || busy !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL %s idle_after_done: busy_next=%0d busy=%b err=%b, want 0 0 0",
                     tag, busy_after, busy, err);
        end
    endtask

    task automatic test_reset();
        #2 pReset_n = 1'b0;
        repeat (3) @(posedge prog_clk);
        @(negedge prog_clk);
        tests++;
        if (bl !== '0 || wl !== '0 || cfg_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            err !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: bl=%h wl=%h ready=%b busy=%b done=%b err=%b, want 0",
                     bl, wl, cfg_ready, busy, done, err);
        end
        @(posedge prog_clk); #1;
        pReset_n = 1'b1;
        @(negedge prog_clk);
        tests++;
        if (busy !== 1'b0 || cfg_ready !== 1'b0 || wl !== '0) begin
            fails++;
            $display("FAIL reset_release_idle: busy=%b ready=%b wl=%h, want 0", busy, cfg_ready,
                     wl);
        end
    endtask

    task automatic test_full_pass();
        run_pass(0, 0, 0, 1'b0, "full_pass");
    endtask

    task automatic test_partial();
        run_pass(157, 2, 0, 1'b0, "partial_157");
    endtask

    task automatic test_illegal_start();
        int bad = 0;
        @(posedge prog_clk); #1;
        start = 1'b1;
        start_row = 8'd158;
        @(posedge prog_clk); #1;
        start = 1'b0;
        @(negedge prog_clk);
        tests++;
        if (err !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
            fails++;
            $display("FAIL illegal_start: err=%b busy=%b ready=%b, want 1 0 0", err, busy,
                     cfg_ready);
        end
        repeat (10) begin
            @(negedge prog_clk);
            if (wl !== '0 || busy !== 1'b0 || err !== 1'b1) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL illegal_quiet: got %0d bad cycles, want 0", bad);
        end
        run_pass(150, 1, 2, 1'b0, "legal_after_illegal");
    endtask

    task automatic test_backpressure();
        run_pass(0, 0, 1, 1'b0, "backpressure");
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        @(posedge prog_clk); #1;
        start = 1'b1;
        start_row = 8'd38;
        @(posedge prog_clk); #1;
        start = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            cfg_valid = 1'b1;
            cfg_data = 8'($urandom_range(1, 255));
            @(negedge prog_clk);
            if (wl[40]) found = 1'b1;
            else begin
                @(posedge prog_clk); #1;
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL reset_mid_wait: wl[40] seen=%b, want 1", found);
        end else begin
            #2 pReset_n = 1'b0;
            #1;
            tests++;
            if (wl !== '0 || bl !== '0 || busy !== 1'b0 || cfg_ready !== 1'b0 ||
                done !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_async: wl=%h bl=%h busy=%b ready=%b done=%b, want 0",
                         wl, bl, busy, cfg_ready, done);
            end
        end
        @(posedge prog_clk); #1;
        cfg_valid = 1'b0;
        pReset_n = 1'b1;
        run_pass(40, 1, 0, 1'b0, "reprogram_40");
    endtask

    task automatic test_start_while_busy();
        run_pass(150, 1, 0, 1'b1, "start_while_busy");
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_partial();
        test_illegal_start();
        test_backpressure();
        test_reset_mid();
        test_start_while_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
